// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types, encodings and burst helpers for the manager and its address generator.
package ahb_pkg;

  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransBusy   = 2'b01,
    HtransNonseq = 2'b10,
    HtransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BurstSingle = 3'b000,
    BurstIncr   = 3'b001,
    BurstWrap4  = 3'b010,
    BurstIncr4  = 3'b011,
    BurstWrap8  = 3'b100,
    BurstIncr8  = 3'b101,
    BurstWrap16 = 3'b110,
    BurstIncr16 = 3'b111
  } hburst_e;

  typedef enum logic [2:0] {
    StIdle,
    StWfetch,
    StAddr,
    StBusy,
    StLastData,
    StErr
  } state_e;

  localparam logic [1:0] HrespOkay    = 2'b00;
  localparam logic [1:0] HrespError   = 2'b01;
  localparam logic [3:0] HprotDefault = 4'b0011;

  // log2 of the beat count; undefined-length INCR is treated as a single beat
  function automatic logic [2:0] burst_lg(input logic [2:0] hburst);
    case (hburst)
      3'b010, 3'b011: burst_lg = 3'd2;
      3'b100, 3'b101: burst_lg = 3'd3;
      3'b110, 3'b111: burst_lg = 3'd4;
      default:        burst_lg = 3'd0;
    endcase
  endfunction

  function automatic logic [4:0] beats_of(input logic [2:0] hburst);
    beats_of = 5'd1 << burst_lg(hburst);
  endfunction

  function automatic logic is_wrap(input logic [2:0] hburst);
    is_wrap = (hburst != 3'b000) && !hburst[0];
  endfunction

endpackage

// File: rtl/ahb_burst_addr_gen.sv
// Next-beat address for AHB bursts: linear increment, or wrap within the aligned burst block.
module ahb_burst_addr_gen
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0]            hsize_i,
  input  logic [2:0]            hburst_i,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] sum;

  always_comb begin
    incr      = ADDR_WIDTH'(1) << hsize_i;
    wrap_mask = (incr << burst_lg(hburst_i)) - ADDR_WIDTH'(1);
    sum       = addr_i + incr;
    if (is_wrap(hburst_i)) begin
      addr_o = (addr_i & ~wrap_mask) | (sum & wrap_mask);
    end else begin
      addr_o = sum;
    end
  end

endmodule

// File: rtl/ahb_manager.sv
// AHB-Lite manager: issues one single/fixed-length burst per local command, with
// wait-state handling, BUSY insertion on write-data starvation and two-cycle ERROR abort.
module ahb_manager
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [2:0]            cmd_size,
  input  logic [2:0]            cmd_burst,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_err,
  output logic                  done,
  output logic                  done_err,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic [1:0]            HRESP,
  input  logic                  HREADY
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_next, align_mask;
  logic                  write_q, write_d;
  logic [2:0]            size_q, size_d;
  logic [2:0]            burst_q, burst_d;
  logic [4:0]            left_q, left_d;
  logic                  first_q, first_d;
  logic                  have_q, have_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
  logic                  dphase_q, dphase_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rdata_valid_q, rdata_valid_d;
  logic                  rdata_err_q, rdata_err_d;
  logic                  done_q, done_d;
  logic                  done_err_q, done_err_d;
  logic                  err_now;
  htrans_e               htrans;

  ahb_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .addr_i  (addr_q),
    .hsize_i (size_q),
    .hburst_i(burst_q),
    .addr_o  (addr_next)
  );

  // First ERROR cycle: the data phase is still stalled
  assign err_now    = dphase_q && (HRESP == HrespError) && !HREADY;
  assign align_mask = (ADDR_WIDTH'(1) << cmd_size) - ADDR_WIDTH'(1);

  assign cmd_ready   = (state_q == StIdle);
  assign HADDR       = addr_q;
  assign HTRANS      = htrans;
  assign HWRITE      = write_q;
  assign HSIZE       = size_q;
  assign HBURST      = burst_q;
  assign HPROT       = HprotDefault;
  assign HWDATA      = hwdata_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign rdata_err   = rdata_err_q;
  assign done        = done_q;
  assign done_err    = done_err_q;

  always_comb begin
    htrans      = HtransIdle;
    wdata_ready = 1'b0;
    case (state_q)
      StWfetch: wdata_ready = 1'b1;
      StAddr: begin
        htrans      = first_q ? HtransNonseq : HtransSeq;
        wdata_ready = write_q && HREADY && (left_q != 5'd1);
      end
      StBusy: begin
        htrans      = HtransBusy;
        wdata_ready = !have_q && !err_now;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    size_d     = size_q;
    burst_d    = burst_q;
    left_d     = left_q;
    first_d    = first_q;
    have_d     = have_q;
    hold_d     = hold_q;
    hwdata_d   = hwdata_q;
    dphase_d   = dphase_q;
    done_d     = 1'b0;
    done_err_d = 1'b0;

    rdata_valid_d = dphase_q && HREADY && !write_q;
    rdata_err_d   = rdata_valid_d && (state_q == StErr);
    rdata_d       = rdata_valid_d ? HRDATA : rdata_q;
    if (HREADY) dphase_d = (state_q == StAddr);

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          write_d = cmd_write;
          size_d  = cmd_size;
          burst_d = (cmd_burst == 3'b001) ? 3'b000 : cmd_burst;
          addr_d  = cmd_addr & ~align_mask;
          left_d  = beats_of(cmd_burst);
          first_d = 1'b1;
          have_d  = 1'b0;
          state_d = cmd_write ? StWfetch : StAddr;
        end
      end
      StWfetch: begin
        if (wdata_valid) begin
          hold_d  = wdata;
          have_d  = 1'b1;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (err_now) begin
          state_d = StErr;
        end else if (HREADY) begin
          first_d = 1'b0;
          if (write_q) begin
            hwdata_d = hold_q;
            have_d   = 1'b0;
          end
          if (left_q == 5'd1) begin
            state_d = StLastData;
          end else begin
            left_d = left_q - 5'd1;
            addr_d = addr_next;
            if (write_q) begin
              if (wdata_valid) begin
                hold_d = wdata;
                have_d = 1'b1;
              end else begin
                state_d = StBusy;
              end
            end
          end
        end
      end
      StBusy: begin
        if (err_now) begin
          state_d = StErr;
        end else begin
          if (wdata_valid && !have_q) begin
            hold_d = wdata;
            have_d = 1'b1;
          end
          if ((have_q || wdata_valid) && HREADY) state_d = StAddr;
        end
      end
      StLastData: begin
        if (err_now) begin
          state_d = StErr;
        end else if (HREADY) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StErr: begin
        if (HREADY) begin
          done_d     = 1'b1;
          done_err_d = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      write_q       <= 1'b0;
      size_q        <= '0;
      burst_q       <= '0;
      left_q        <= '0;
      first_q       <= 1'b0;
      have_q        <= 1'b0;
      hold_q        <= '0;
      hwdata_q      <= '0;
      dphase_q      <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      rdata_err_q   <= 1'b0;
      done_q        <= 1'b0;
      done_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      write_q       <= write_d;
      size_q        <= size_d;
      burst_q       <= burst_d;
      left_q        <= left_d;
      first_q       <= first_d;
      have_q        <= have_d;
      hold_q        <= hold_d;
      hwdata_q      <= hwdata_d;
      dphase_q      <= dphase_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      rdata_err_q   <= rdata_err_d;
      done_q        <= done_d;
      done_err_q    <= done_err_d;
    end
  end

endmodule

// File: doc/ahb_manager.md
Name: ahb_manager

Overview:
- AHB-Lite manager (initiator) that sits on the manager side of the existing decoder/mux/subordinate fabric.
- Accepts one transfer command at a time from a local command port and issues it as a pipelined AHB-Lite single or fixed-length burst.
- Drives the address and data phases, honours HREADY wait states and the two-cycle ERROR response.
- Streams write data in and read data out.

Parameters:
- ADDR_WIDTH, 32, width of HADDR and cmd_addr.
- DATA_WIDTH, 32, width of HWDATA/HRDATA and the local data ports.

Ports:
- HCLK  input  1  bus clock.
- HRESETn  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_WIDTH  start address.
- cmd_size  input  3  HSIZE value; 0..log2(DATA_WIDTH/8) legal.
- cmd_burst  input  3  HBURST encoding.
- wdata_valid  input  1  write beat available.
- wdata_ready  output  1  write beat consumed when wdata_valid && wdata_ready.
- wdata  input  DATA_WIDTH  write beat.
- rdata_valid  output  1  one-cycle read beat strobe (no backpressure).
- rdata  output  DATA_WIDTH  read beat.
- rdata_err  output  1  qualifies rdata_valid; 1 means the beat ended in ERROR.
- done  output  1  one-cycle pulse when a command completes.
- done_err  output  1  valid with done; 1 means the burst was aborted by ERROR.
- HADDR  output  ADDR_WIDTH  bus address.
- HTRANS  output  2  transfer type.
- HWRITE  output  1  transfer direction.
- HSIZE  output  3  transfer size.
- HBURST  output  3  burst type.
- HPROT  output  4  protection; constant 4'b0011.
- HWDATA  output  DATA_WIDTH  write data.
- HRDATA  input  DATA_WIDTH  read data.
- HRESP  input  2  response; 2'b00 OKAY, 2'b01 ERROR.
- HREADY  input  1  transfer-complete indication from the mux.

Behaviour:
- Interface (already decided): one clock, HCLK; reset HRESETn is asynchronous and active-low.
- Reset values:
  - HTRANS = IDLE (2'b00); HADDR, HWRITE, HSIZE, HBURST, HWDATA all 0; HPROT = 4'b0011.
  - cmd_ready = 1; wdata_ready = 0; rdata_valid, rdata_err, done, done_err = 0; rdata = 0.
  - FSM = IDLE.
- Reset asserted mid-burst: outputs return to reset values immediately; the outstanding beat is dropped with no done pulse.
- Address-phase outputs (HADDR, HTRANS, HWRITE, HSIZE, HBURST) change only on a rising edge where HREADY = 1, except in the ERROR cancel case below.
- Beat count:
  - SINGLE = 1; WRAP4/INCR4 = 4; WRAP8/INCR8 = 8; WRAP16/INCR16 = 16.
  - INCR (undefined length, 3'b001) is issued as SINGLE: 1 beat, HBURST driven 3'b000.
- Address generation:
  - Start address is aligned down to 1 << cmd_size.
  - Each beat adds 1 << HSIZE.
  - INCRx bursts do not cross a 1 KB boundary; the command source guarantees this.
  - WRAPx bursts wrap within an aligned block of beats × (1 << HSIZE) bytes; e.g. WRAP4, size 2, start 0x38 gives 0x38, 0x3C, 0x30, 0x34.
- FSM states:
  - IDLE: cmd_ready = 1. On accept, latch the command. Read goes to ADDR; write goes to WFETCH.
  - WFETCH: wdata_ready = 1. On handshake, load the holding register and go to ADDR (first beat) or continue the burst.
  - ADDR: drive NONSEQ on the first beat, SEQ on later beats.
    - On HREADY = 1: the beat enters its data phase. For writes, HWDATA <= holding register and wdata_ready pulses to prefetch the next beat.
    - After the last beat: go to LASTDATA.
  - BUSY: entered mid-write-burst when the next beat's data is not yet held.
    - Drive HTRANS = BUSY (2'b01), holding HADDR at the next beat's address.
    - Return to ADDR (SEQ) the cycle after the data arrives.
    - Never entered for reads.
  - LASTDATA: HTRANS = IDLE. Wait for HREADY = 1 on the final data phase, then pulse done (done_err = 0) and go to IDLE.
  - ERR: see the ERROR response rule.
- Read data: rdata_valid pulses in the cycle after the data phase completes (HREADY = 1), with rdata registered from HRDATA and rdata_err = 0.
- ERROR response:
  - Trigger: HRESP = ERROR while HREADY = 0 in any data phase.
  - On the next edge, HTRANS is forced to IDLE regardless of HREADY, and the remaining beats are abandoned (no further wdata handshakes).
  - When the second ERROR cycle (HREADY = 1) completes:
    - done = 1, done_err = 1.
    - For reads, rdata_valid = 1 and rdata_err = 1.
    - FSM returns to IDLE.
- Simultaneous events: cmd_valid during a burst is ignored because cmd_ready = 0. wdata_valid in IDLE is not consumed.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS enum: IDLE, BUSY, NONSEQ, SEQ.
  - HBURST enum and HRESP constants.
  - beats_of(hburst) function and the HPROT default.
- One sub-module, ahb_burst_addr_gen: combinational next-address logic (increment/wrap) from current address, HSIZE and HBURST.
- The manager instantiates ahb_burst_addr_gen and holds the FSM, beat counter and data registers.

Test Plan:
- SINGLE write 0x0000_0010 = 0xDEADBEEF, zero-wait fabric:
  - NONSEQ then IDLE on HTRANS; HWDATA = 0xDEADBEEF one cycle after the address phase.
  - done pulses 2 cycles after the address phase.
- INCR4 read from 0x20, size 2, subordinate inserts 2 wait states on beat 2:
  - HADDR sequence 0x20, 0x24, 0x28, 0x2C; HADDR held during the waits.
  - 4 rdata_valid pulses in order; done_err = 0.
- WRAP4 write from 0x38, size 2, with wdata_valid withheld 3 cycles before beat 3:
  - Addresses 0x38, 0x3C, 0x30, 0x34.
  - HTRANS = BUSY for the stall cycles, then SEQ.
- INCR8 read hitting the default subordinate (ERROR) on beat 1:
  - HTRANS = IDLE in the second ERROR cycle.
  - One rdata_valid with rdata_err = 1; done with done_err = 1; no further beats.
- HRESETn asserted during beat 3 of INCR16:
  - All outputs return to reset values asynchronously.
  - After release, a new SINGLE read completes normally.
